// File: rtl/tl_pkg.sv
// Shared types and helpers for the traffic-light fault monitor.
// Lamp patterns are handled as {red, yellow, green}.
package tl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MON   = 2'd1,
    ST_FAULT = 2'd2
  } tl_state_e;

  typedef enum logic [1:0] {
    LAMP_NONE   = 2'd0,
    LAMP_RED    = 2'd1,
    LAMP_YELLOW = 2'd2,
    LAMP_GREEN  = 2'd3
  } tl_lamp_e;

  localparam logic [2:0] FC_NONE       = 3'd0;
  localparam logic [2:0] FC_ONEHOT     = 3'd1;
  localparam logic [2:0] FC_TRANSITION = 3'd2;
  localparam logic [2:0] FC_TIMEOUT    = 3'd3;

  function automatic logic is_onehot3(input logic [2:0] p);
    logic r_s;
    case (p)
      3'b100, 3'b010, 3'b001: r_s = 1'b1;
      default:                r_s = 1'b0;
    endcase
    return r_s;
  endfunction

  function automatic tl_lamp_e lamp_of(input logic [2:0] p);
    tl_lamp_e l_s;
    case (p)
      3'b100:  l_s = LAMP_RED;
      3'b010:  l_s = LAMP_YELLOW;
      3'b001:  l_s = LAMP_GREEN;
      default: l_s = LAMP_NONE;
    endcase
    return l_s;
  endfunction

  // Only the forward rotation G->Y->R->G is a legal lamp change.
  function automatic logic legal_step(input tl_lamp_e from, input tl_lamp_e to);
    logic r_s;
    case (from)
      LAMP_GREEN:  r_s = (to == LAMP_YELLOW);
      LAMP_YELLOW: r_s = (to == LAMP_RED);
      LAMP_RED:    r_s = (to == LAMP_GREEN);
      default:     r_s = 1'b0;
    endcase
    return r_s;
  endfunction

endpackage

// File: rtl/tl_flash_gen.sv
// Failsafe yellow flasher: output sits at 1 while disabled and toggles
// every FLASH_HALF enabled cycles.
module tl_flash_gen #(
  parameter int FLASH_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic yellow
);

  localparam int CW = $clog2(FLASH_HALF + 1);
  localparam logic [CW-1:0] LAST_C = CW'(FLASH_HALF - 1);

  logic [CW-1:0] cnt_r;
  logic          tog_r;

  // Half-period counter and toggle register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      tog_r <= 1'b1;
    end else if (!enable) begin
      cnt_r <= {CW{1'b0}};
      tog_r <= 1'b1;
    end else if (cnt_r == LAST_C) begin
      cnt_r <= {CW{1'b0}};
      tog_r <= ~tog_r;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign yellow = tog_r;

endmodule

// File: rtl/light_fault_monitor.sv
// Supervises lamp commands from the traffic_light controller: passes them
// through while legal, latches the first fault and falls back to flashing yellow.
module light_fault_monitor
  import tl_pkg::*;
#(
  parameter int MAX_GREEN  = 20,
  parameter int MAX_YELLOW = 8,
  parameter int MAX_RED    = 20,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       red_in,
  input  logic       yellow_in,
  input  logic       green_in,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] cycle_count
);

  if ((MAX_GREEN < 1) || (MAX_GREEN > 254) || (MAX_YELLOW < 1) || (MAX_YELLOW > 254) ||
      (MAX_RED < 1) || (MAX_RED > 254) || (FLASH_HALF < 1)) begin : g_bad_params
    $error("light_fault_monitor: MAX_* must be 1..254 and FLASH_HALF >= 1");
  end

  localparam logic [7:0] MAX_G_C = 8'(MAX_GREEN);
  localparam logic [7:0] MAX_Y_C = 8'(MAX_YELLOW);
  localparam logic [7:0] MAX_R_C = 8'(MAX_RED);

  logic [2:0] smp_r;
  tl_state_e  state_r, state_nxt_s;
  tl_lamp_e   cur_r, cur_nxt_s, smp_lamp_s;
  logic [7:0] dwell_r, dwell_nxt_s, dwell_inc_s, max_cur_s;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic [2:0] code_r, code_nxt_s;
  logic [2:0] lamp_r, lamp_nxt_s;
  logic       fault_r;
  logic       flash_s;

  tl_flash_gen #(.FLASH_HALF(FLASH_HALF)) u_flash (
    .clk    (clk),
    .rst    (rst),
    .enable (state_nxt_s == ST_FAULT),
    .yellow (flash_s)
  );

  // Next-state, fault classification and lamp selection.
  always_comb begin
    state_nxt_s = state_r;
    cur_nxt_s   = cur_r;
    dwell_nxt_s = dwell_r;
    cnt_nxt_s   = cnt_r;
    code_nxt_s  = code_r;
    smp_lamp_s  = lamp_of(smp_r);
    dwell_inc_s = (dwell_r == 8'd255) ? 8'd255 : dwell_r + 8'd1;
    lamp_nxt_s  = 3'b100;

    case (cur_r)
      LAMP_RED:    max_cur_s = MAX_R_C;
      LAMP_YELLOW: max_cur_s = MAX_Y_C;
      LAMP_GREEN:  max_cur_s = MAX_G_C;
      default:     max_cur_s = 8'd1;
    endcase

    case (state_r)
      ST_IDLE: begin
        if (is_onehot3(smp_r)) begin
          state_nxt_s = ST_MON;
          cur_nxt_s   = smp_lamp_s;
          dwell_nxt_s = 8'd1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MON: begin
        // Priority falls out of the if-chain: one-hot, then transition, then timeout.
        if (!is_onehot3(smp_r)) begin
          state_nxt_s = ST_FAULT;
          code_nxt_s  = FC_ONEHOT;
        end else if (smp_lamp_s != cur_r) begin
          if (legal_step(cur_r, smp_lamp_s)) begin
            cur_nxt_s   = smp_lamp_s;
            dwell_nxt_s = 8'd1;
            cnt_nxt_s   = (cur_r == LAMP_RED) ? cnt_r + 8'd1 : cnt_r;
          end else begin
            state_nxt_s = ST_FAULT;
            code_nxt_s  = FC_TRANSITION;
          end
        end else begin
          dwell_nxt_s = dwell_inc_s;
          if (dwell_inc_s > max_cur_s) begin
            state_nxt_s = ST_FAULT;
            code_nxt_s  = FC_TIMEOUT;
          end else begin
            state_nxt_s = ST_MON;
          end
        end
      end
      ST_FAULT: state_nxt_s = ST_FAULT;
      default:  state_nxt_s = ST_FAULT;
    endcase

    case (state_nxt_s)
      ST_MON:   lamp_nxt_s = smp_r;
      ST_FAULT: lamp_nxt_s = {1'b0, flash_s, 1'b0};
      default:  lamp_nxt_s = 3'b100;
    endcase
  end

  // Sample, state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_r   <= 3'b000;
      state_r <= ST_IDLE;
      cur_r   <= LAMP_NONE;
      dwell_r <= 8'd0;
      cnt_r   <= 8'd0;
      code_r  <= FC_NONE;
      lamp_r  <= 3'b100;
      fault_r <= 1'b0;
    end else begin
      smp_r   <= {red_in, yellow_in, green_in};
      state_r <= state_nxt_s;
      cur_r   <= cur_nxt_s;
      dwell_r <= dwell_nxt_s;
      cnt_r   <= cnt_nxt_s;
      code_r  <= code_nxt_s;
      lamp_r  <= lamp_nxt_s;
      fault_r <= (state_nxt_s == ST_FAULT);
    end
  end

  assign {lamp_red, lamp_yellow, lamp_green} = lamp_r;
  assign fault       = fault_r;
  assign fault_code  = code_r;
  assign cycle_count = cnt_r;

endmodule

// File: tb/tb_light_fault_monitor.sv
// Self-checking bench for light_fault_monitor: vector table, directed corner
// sequences and randomized traffic against a lamp-level reference model.
module tb_light_fault_monitor;

  localparam int FH   = 4;
  localparam int MAXG = 20;
  localparam int MAXY = 8;
  localparam int MAXR = 20;
  localparam logic [2:0] PR = 3'b100;
  localparam logic [2:0] PY = 3'b010;
  localparam logic [2:0] PG = 3'b001;

  logic clk = 1'b0;
  logic rst, red_in, yellow_in, green_in;
  logic lamp_red, lamp_yellow, lamp_green, fault;
  logic [2:0] fault_code;
  logic [7:0] cycle_count;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  light_fault_monitor #(
    .MAX_GREEN(MAXG), .MAX_YELLOW(MAXY), .MAX_RED(MAXR), .FLASH_HALF(FH)
  ) dut (
    .clk(clk), .rst(rst),
    .red_in(red_in), .yellow_in(yellow_in), .green_in(green_in),
    .lamp_red(lamp_red), .lamp_yellow(lamp_yellow), .lamp_green(lamp_green),
    .fault(fault), .fault_code(fault_code), .cycle_count(cycle_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 monitoring, 2 failed; patterns as {r,y,g}.
  int m_mode, m_dwell, m_cnt, m_code, m_age;
  logic [2:0] m_cur, m_smp, m_lamps;

  function automatic int max_of(input logic [2:0] p);
    return (p == PY) ? MAXY : ((p == PG) ? MAXG : MAXR);
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] p);
    return (p == PR) ? PG : ((p == PG) ? PY : PR);
  endfunction

  task automatic model_fault(input int c);
    m_mode = 2; m_code = c; m_age = 0;
  endtask

  task automatic model_step(input logic r, input logic [2:0] pat);
    logic [2:0] p;
    if (r) begin
      m_mode = 0; m_cur = 3'b000; m_dwell = 0; m_cnt = 0; m_code = 0; m_age = 0;
      m_smp = 3'b000; m_lamps = PR;
      return;
    end
    p = m_smp;
    if (m_mode == 0) begin
      if ($countones(p) == 1) begin m_mode = 1; m_cur = p; m_dwell = 1; end
    end else if (m_mode == 1) begin
      if ($countones(p) != 1) model_fault(1);
      else if (p != m_cur) begin
        if (p == succ(m_cur)) begin
          if (m_cur == PR) m_cnt = (m_cnt + 1) % 256;
          m_cur = p; m_dwell = 1;
        end else model_fault(2);
      end else begin
        m_dwell = (m_dwell >= 255) ? 255 : m_dwell + 1;
        if (m_dwell > max_of(m_cur)) model_fault(3);
      end
    end else begin
      m_age++;
    end
    if (m_mode == 0)      m_lamps = PR;
    else if (m_mode == 1) m_lamps = p;
    else                  m_lamps = (((m_age / FH) % 2) == 0) ? PY : 3'b000;
    m_smp = pat;
  endtask

  task automatic cyc(input logic r, input logic [2:0] pat);
    rst = r;
    {red_in, yellow_in, green_in} = pat;
    @(posedge clk);
    model_step(r, pat);
    #1;
    check("model_lamps", {lamp_red, lamp_yellow, lamp_green}, m_lamps);
    check("model_fault", fault, (m_mode == 2));
    check("model_code", fault_code, m_code);
    check("model_count", cycle_count, m_cnt);
  endtask

  task automatic hold(input logic [2:0] pat, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, pat);
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] pat;
    logic [2:0] lamps;
    logic       flt;
    logic [2:0] code;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[17];
  logic [2:0] lastpat;

  initial begin
    tbl[0]  = '{1'b1, 3'b000, 3'b100, 1'b0, 3'd0, 8'd0};
    tbl[1]  = '{1'b0, 3'b100, 3'b100, 1'b0, 3'd0, 8'd0};
    tbl[2]  = '{1'b0, 3'b100, 3'b100, 1'b0, 3'd0, 8'd0};
    tbl[3]  = '{1'b0, 3'b001, 3'b100, 1'b0, 3'd0, 8'd0};
    tbl[4]  = '{1'b0, 3'b001, 3'b001, 1'b0, 3'd0, 8'd1};
    tbl[5]  = '{1'b0, 3'b010, 3'b001, 1'b0, 3'd0, 8'd1};
    tbl[6]  = '{1'b0, 3'b010, 3'b010, 1'b0, 3'd0, 8'd1};
    tbl[7]  = '{1'b0, 3'b100, 3'b010, 1'b0, 3'd0, 8'd1};
    tbl[8]  = '{1'b0, 3'b100, 3'b100, 1'b0, 3'd0, 8'd1};
    tbl[9]  = '{1'b0, 3'b010, 3'b100, 1'b0, 3'd0, 8'd1};
    tbl[10] = '{1'b0, 3'b010, 3'b010, 1'b1, 3'd2, 8'd1};
    tbl[11] = '{1'b0, 3'b001, 3'b010, 1'b1, 3'd2, 8'd1};
    tbl[12] = '{1'b0, 3'b001, 3'b010, 1'b1, 3'd2, 8'd1};
    tbl[13] = '{1'b0, 3'b001, 3'b010, 1'b1, 3'd2, 8'd1};
    tbl[14] = '{1'b0, 3'b001, 3'b000, 1'b1, 3'd2, 8'd1};
    tbl[15] = '{1'b0, 3'b001, 3'b000, 1'b1, 3'd2, 8'd1};
    tbl[16] = '{1'b1, 3'b001, 3'b100, 1'b0, 3'd0, 8'd0};

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].rst, tbl[i].pat);
      check($sformatf("tbl%0d_lamps", i), {lamp_red, lamp_yellow, lamp_green}, tbl[i].lamps);
      check($sformatf("tbl%0d_fault", i), fault, tbl[i].flt);
      check($sformatf("tbl%0d_code", i), fault_code, tbl[i].code);
      check($sformatf("tbl%0d_count", i), cycle_count, tbl[i].cnt);
    end

    // Three legal R10/G10/Y5 rounds, then red again with a 2-cycle lag.
    cyc(1'b1, 3'b000);
    for (int k = 0; k < 3; k++) begin
      hold(PR, 10); hold(PG, 10); hold(PY, 5);
    end
    cyc(1'b0, PR);
    check("lag_still_yellow", {lamp_red, lamp_yellow, lamp_green}, 3'b010);
    cyc(1'b0, PR);
    check("lag_now_red", {lamp_red, lamp_yellow, lamp_green}, 3'b100);
    check("three_rounds_count", cycle_count, 8'd3);
    check("three_rounds_fault", fault, 1'b0);

    // G->R is illegal; the failsafe flashes 4 on / 4 off and ignores inputs.
    cyc(1'b1, 3'b000);
    hold(PR, 5); hold(PG, 3);
    cyc(1'b0, PR);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 3'($urandom_range(0, 7)));
      check("flash_yellow", lamp_yellow, (((i / 4) % 2) == 0));
      check("flash_red_green", {lamp_red, lamp_green}, 2'b00);
    end
    check("gr_code", fault_code, 3'd2);
    check("gr_count_frozen", cycle_count, 8'd1);

    // Two lamps at once: one-hot fault wins over the illegal transition.
    cyc(1'b1, 3'b000);
    hold(PR, 3);
    cyc(1'b0, 3'b101);
    cyc(1'b0, 3'b101);
    check("both_fault", fault, 1'b1);
    check("both_code", fault_code, 3'd1);

    // Yellow dwell of exactly 8 is legal.
    cyc(1'b1, 3'b000);
    hold(PR, 3); hold(PG, 3); hold(PY, 8); hold(PR, 3);
    check("yellow8_fault", fault, 1'b0);

    // Yellow dwell reaching 9 times out on that very edge.
    cyc(1'b1, 3'b000);
    hold(PR, 3); hold(PG, 3); hold(PY, 9);
    check("yellow_dwell8_fault", fault, 1'b0);
    cyc(1'b0, PY);
    check("yellow_dwell9_fault", fault, 1'b1);
    check("yellow_dwell9_code", fault_code, 3'd3);

    // Reset out of FAULT, then re-enter monitoring.
    cyc(1'b1, PG);
    check("rst_lamps", {lamp_red, lamp_yellow, lamp_green}, 3'b100);
    check("rst_fault", fault, 1'b0);
    check("rst_code", fault_code, 3'd0);
    check("rst_count", cycle_count, 8'd0);
    hold(PR, 2); hold(PG, 2);
    check("reenter_green", {lamp_red, lamp_yellow, lamp_green}, 3'b001);
    check("reenter_count", cycle_count, 8'd1);

    // 256 legal rounds wrap the counter.
    cyc(1'b1, 3'b000);
    for (int k = 0; k < 256; k++) begin
      if (k == 255) check("count_255", cycle_count, 8'd255);
      hold(PR, 3); hold(PG, 3); hold(PY, 3);
    end
    hold(PR, 3);
    check("wrap_count", cycle_count, 8'd0);
    check("wrap_fault", fault, 1'b0);

    // Random traffic: mostly legal rotation with random dwell, some glitches and resets.
    cyc(1'b1, 3'b000);
    lastpat = PY;
    for (int s = 0; s < 300; s++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        cyc(1'b1, 3'($urandom_range(0, 7)));
      end else if (r < 14) begin
        cyc(1'b0, 3'($urandom_range(0, 7)));
      end else begin
        lastpat = succ(lastpat);
        hold(lastpat, $urandom_range(1, 24));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
